// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and parity-checker FSM states.
// Also used by the TX parity stage, so keep encodings stable.
package uart_pkg;

    localparam logic [2:0] PAR_EVEN  = 3'd0;
    localparam logic [2:0] PAR_ODD   = 3'd1;
    localparam logic [2:0] PAR_MARK  = 3'd2;
    localparam logic [2:0] PAR_SPACE = 3'd3;
    localparam logic [2:0] PAR_NONE  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } par_state_e;

endpackage

// File: rtl/uart_parity_gen.sv
// Expected parity bit from data and mode; purely combinational, no backpressure.
// Modes 4..7 (none) produce 0; callers decide whether the bit is checked at all.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [2:0]            i_mode,
    output logic                  o_par
);

    always_comb begin
        o_par = 1'b0;
        case (i_mode)
            PAR_EVEN:  o_par = ^i_data;
            PAR_ODD:   o_par = ~^i_data;
            PAR_MARK:  o_par = 1'b1;
            PAR_SPACE: o_par = 1'b0;
            default:   o_par = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_rx_parity_unit.sv
// UART RX parity checker: one check per frame, result pulse 1 cycle after the strobe.
// No backpressure; sticky flag and saturating counter are held until err_clr or RST.
module uart_rx_parity_unit
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  par_chk_en,
    input  logic [2:0]            PAR_MODE,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [BIT_CNT_W-1:0]  bit_cnt,
    input  logic                  sampled_bit,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  err_clr,
    output logic                  par_valid,
    output logic                  par_err,
    output logic                  par_err_sticky,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    par_state_e           r_state;
    logic [2:0]           r_mode;
    logic                 r_par_valid;
    logic                 r_par_err;
    logic                 r_sticky;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic w_strobe;
    logic w_exp_par;
    logic w_mismatch;
    logic w_err_now;

    // Sample point sits two edges before the end of the parity bit, wrapping in PRESCALE_W bits.
    assign w_strobe = par_chk_en
                    && (bit_cnt == BIT_CNT_W'(DATA_WIDTH + 1))
                    && (edge_cnt == (Prescale - PRESCALE_W'(2)));

    uart_parity_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_gen (
        .i_data (P_DATA),
        .i_mode (r_mode),
        .o_par  (w_exp_par)
    );

    assign w_mismatch = (r_mode <= PAR_SPACE) && (sampled_bit != w_exp_par);
    assign w_err_now  = (r_state == ST_ARMED) && w_strobe && w_mismatch;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_mode      <= PAR_NONE;
            r_par_valid <= 1'b0;
            r_par_err   <= 1'b0;
        end else begin
            r_par_valid <= 1'b0;
            r_par_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (par_chk_en) begin
                        r_state <= ST_ARMED;
                        r_mode  <= PAR_MODE;
                    end
                end
                ST_ARMED: begin
                    if (!par_chk_en) begin
                        r_state <= ST_IDLE;
                    end else if (w_strobe) begin
                        r_state     <= ST_DONE;
                        r_par_valid <= 1'b1;
                        r_par_err   <= w_mismatch;
                    end
                end
                ST_DONE: begin
                    if (!par_chk_en) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A fresh error takes priority over a simultaneous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sticky  <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_err_now) begin
            r_sticky <= 1'b1;
            if (err_clr) begin
                r_err_cnt <= ERR_CNT_W'(1);
            end else if (!(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            r_sticky  <= 1'b0;
            r_err_cnt <= '0;
        end
    end

    assign par_valid      = r_par_valid;
    assign par_err        = r_par_err;
    assign par_err_sticky = r_sticky;
    assign err_cnt        = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_parity_unit.sv
// Directed bench for uart_rx_parity_unit (DATA_WIDTH=8, ERR_CNT_W=2 to reach saturation quickly).
module tb_uart_rx_parity_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic       par_chk_en;
    logic [2:0] PAR_MODE;
    logic [5:0] Prescale;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic [7:0] P_DATA;
    logic       err_clr;
    logic       par_valid;
    logic       par_err;
    logic       par_err_sticky;
    logic [1:0] err_cnt;

    int errors = 0;
    int checks = 0;

    uart_rx_parity_unit #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6),
        .BIT_CNT_W  (4),
        .ERR_CNT_W  (2)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .par_chk_en     (par_chk_en),
        .PAR_MODE       (PAR_MODE),
        .Prescale       (Prescale),
        .edge_cnt       (edge_cnt),
        .bit_cnt        (bit_cnt),
        .sampled_bit    (sampled_bit),
        .P_DATA         (P_DATA),
        .err_clr        (err_clr),
        .par_valid      (par_valid),
        .par_err        (par_err),
        .par_err_sticky (par_err_sticky),
        .err_cnt        (err_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic e,
                           input logic s, input logic [1:0] c);
        chk({tag, ".valid"},  {31'd0, par_valid},      {31'd0, v});
        chk({tag, ".err"},    {31'd0, par_err},        {31'd0, e});
        chk({tag, ".sticky"}, {31'd0, par_err_sticky}, {31'd0, s});
        chk({tag, ".cnt"},    {30'd0, err_cnt},        {30'd0, c});
    endtask

    // Arm with mode, then present the parity-bit strobe; returns just after the result edge.
    task automatic frame(input logic [2:0] mode, input logic [7:0] data,
                         input logic sb, input logic clr);
        PAR_MODE   = mode;
        par_chk_en = 1'b1;
        bit_cnt    = 4'd0;
        edge_cnt   = 6'd0;
        step();
        P_DATA      = data;
        sampled_bit = sb;
        bit_cnt     = 4'd9;
        edge_cnt    = Prescale - 6'd2;
        err_clr     = clr;
        step();
        err_clr = 1'b0;
    endtask

    task automatic end_frame();
        par_chk_en = 1'b0;
        bit_cnt    = 4'd0;
        edge_cnt   = 6'd0;
        step();
    endtask

    initial begin
        RST = 1'b1; par_chk_en = 1'b0; PAR_MODE = 3'd0; Prescale = 6'd8;
        edge_cnt = 6'd0; bit_cnt = 4'd0; sampled_bit = 1'b0; P_DATA = 8'h00; err_clr = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        RST = 1'b0;
        step();

        // Even, A5 has four ones -> expected 0, received 0.
        frame(3'd0, 8'hA5, 1'b0, 1'b0);
        chk_out("even_ok", 1'b1, 1'b0, 1'b0, 2'd0);
        edge_cnt = 6'd7;
        step();
        chk("even_pulse_width", {31'd0, par_valid}, 32'd0);
        end_frame();

        // Odd, 01 -> expected 0, received 1: error; a repeated strobe is ignored.
        frame(3'd1, 8'h01, 1'b1, 1'b0);
        chk_out("odd_err", 1'b1, 1'b1, 1'b1, 2'd1);
        edge_cnt = 6'd7;
        step();
        edge_cnt = 6'd6;
        step();
        chk("second_strobe", {31'd0, par_valid}, 32'd0);
        end_frame();

        frame(3'd2, 8'h00, 1'b0, 1'b0);
        chk_out("mark_err", 1'b1, 1'b1, 1'b1, 2'd2);
        end_frame();
        frame(3'd3, 8'hFF, 1'b0, 1'b0);
        chk_out("space_ok", 1'b1, 1'b0, 1'b1, 2'd2);
        end_frame();
        frame(3'd4, 8'h01, 1'b0, 1'b0);
        chk_out("none0", 1'b1, 1'b0, 1'b1, 2'd2);
        end_frame();
        frame(3'd7, 8'h00, 1'b1, 1'b0);
        chk_out("none7", 1'b1, 1'b0, 1'b1, 2'd2);
        end_frame();

        // Counter saturates at 3 with ERR_CNT_W=2.
        for (int i = 0; i < 5; i++) begin
            frame(3'd2, 8'h00, 1'b0, 1'b0);
            end_frame();
        end
        chk_out("saturate", 1'b0, 1'b0, 1'b1, 2'd3);
        frame(3'd2, 8'h00, 1'b0, 1'b1);
        chk_out("clr_vs_err", 1'b1, 1'b1, 1'b1, 2'd1);
        end_frame();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk_out("clr_only", 1'b0, 1'b0, 1'b0, 2'd0);

        // Abort mid-frame: later strobe-like inputs with enable low produce nothing.
        PAR_MODE = 3'd0; par_chk_en = 1'b1;
        step();
        bit_cnt = 4'd5; par_chk_en = 1'b0;
        step();
        bit_cnt = 4'd9; edge_cnt = 6'd6; P_DATA = 8'hA5; sampled_bit = 1'b1;
        step();
        chk("abort_no_valid", {31'd0, par_valid}, 32'd0);
        step();
        chk("abort_no_valid2", {31'd0, par_valid}, 32'd0);

        // Enable and strobe together in IDLE only arms; the check lands one cycle later.
        par_chk_en = 1'b1; sampled_bit = 1'b0;
        step();
        chk("idle_strobe_arm", {31'd0, par_valid}, 32'd0);
        step();
        chk_out("idle_strobe_chk", 1'b1, 1'b0, 1'b0, 2'd0);
        end_frame();

        // Mode changed to odd while armed: still checked as even.
        PAR_MODE = 3'd0; par_chk_en = 1'b1;
        step();
        PAR_MODE = 3'd1; P_DATA = 8'hA5; sampled_bit = 1'b0; bit_cnt = 4'd9; edge_cnt = 6'd6;
        step();
        chk_out("mode_latched", 1'b1, 1'b0, 1'b0, 2'd0);
        end_frame();

        // Prescale=4 puts the strobe at edge 2, not edge 6.
        Prescale = 6'd4;
        PAR_MODE = 3'd0; par_chk_en = 1'b1;
        step();
        P_DATA = 8'h00; sampled_bit = 1'b1; bit_cnt = 4'd9; edge_cnt = 6'd6;
        step();
        chk("presc4_edge6", {31'd0, par_valid}, 32'd0);
        edge_cnt = 6'd2;
        step();
        chk_out("presc4_edge2", 1'b1, 1'b1, 1'b1, 2'd1);
        end_frame();
        Prescale = 6'd8;

        // Reset just before the strobe discards the pending check.
        PAR_MODE = 3'd2; par_chk_en = 1'b1;
        step();
        P_DATA = 8'h00; sampled_bit = 1'b0; bit_cnt = 4'd9; edge_cnt = 6'd5;
        step();
        #2;
        RST = 1'b1;
        #1;
        chk_out("rst_async", 1'b0, 1'b0, 1'b0, 2'd0);
        edge_cnt = 6'd6;
        step();
        par_chk_en = 1'b0;
        RST = 1'b0;
        step();
        chk_out("rst_release", 1'b0, 1'b0, 1'b0, 2'd0);
        step();
        chk_out("rst_after", 1'b0, 1'b0, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
